// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one Booth multiplier between two requesters
//
// Purpose:
//   Two requesters present signed operand pairs. The arbiter picks one
//   (round-robin on simultaneous requests), loads the shared multiplier,
//   waits for its result with a timeout, and returns the product to the
//   owner. Every output is registered.
//
// Ports:
//   Clk              clock, rising edge
//   Rst              asynchronous active-low reset
//   req0/req1        request from requester 0 / 1
//   m0,r0 / m1,r1    signed multiplicand / multiplier per requester
//   gnt0/gnt1        one-cycle pulse: operands taken
//   done0/done1      one-cycle pulse: result valid on p0/p1
//   p0/p1            last result per requester, held between done pulses
//   err              one-cycle pulse: multiplier timed out
//   busy             high whenever the arbiter is not idle
//   mul_ld           load strobe to the multiplier
//   mul_m/mul_r      operands to the multiplier
//   mul_valid        multiplier result-ready
//   mul_p            multiplier product

module mult_arbiter #(
    parameter int pN   = 2,
    parameter int pTMO = 2**(pN+2)+4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    req0,
    input  logic                    req1,
    input  logic [2**pN-1:0]        m0,
    input  logic [2**pN-1:0]        r0,
    input  logic [2**pN-1:0]        m1,
    input  logic [2**pN-1:0]        r1,
    output logic                    gnt0,
    output logic                    gnt1,
    output logic                    done0,
    output logic                    done1,
    output logic [2**(pN+1)-1:0]    p0,
    output logic [2**(pN+1)-1:0]    p1,
    output logic                    err,
    output logic                    busy,
    output logic                    mul_ld,
    output logic [2**pN-1:0]        mul_m,
    output logic [2**pN-1:0]        mul_r,
    input  logic                    mul_valid,
    input  logic [2**(pN+1)-1:0]    mul_p
);

    localparam int CW = $clog2(pTMO + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t         r_state;
    logic           r_owner;    // requester that owns the operation in flight
    logic           r_last;     // requester granted most recently
    logic [CW-1:0]  r_cnt;      // WAIT cycles elapsed without mul_valid

    logic           w_win;

    // A lone requester always wins; on a tie the one not granted last wins.
    assign w_win = (req0 && req1) ? ~r_last : req1;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            mul_ld  <= 1'b0;
            mul_m   <= '0;
            mul_r   <= '0;
            p0      <= '0;
            p1      <= '0;
        end else begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            err    <= 1'b0;
            mul_ld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        // mul_m/mul_r double as the operand latch, so the
                        // operands are committed here and held until the
                        // next grant.
                        r_owner <= w_win;
                        r_last  <= w_win;
                        mul_m   <= w_win ? m1 : m0;
                        mul_r   <= w_win ? r1 : r0;
                        gnt0    <= ~w_win;
                        gnt1    <= w_win;
                        mul_ld  <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_valid) begin
                        if (r_owner) begin
                            p1    <= mul_p;
                            done1 <= 1'b1;
                        end else begin
                            p0    <= mul_p;
                            done0 <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end else if (r_cnt == CW'(pTMO - 1)) begin
                        // this is the pTMO-th WAIT cycle without a result
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - self-checking bench for mult_arbiter with a transaction-level model

module tb_mult_arbiter;

    localparam int TMO = 20;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] m0 = '0, r0 = '0, m1 = '0, r1 = '0;
    logic       gnt0, gnt1, done0, done1, err, busy, mul_ld;
    logic [7:0] p0, p1;
    logic [3:0] mul_m, mul_r;
    logic       mul_valid = 1'b0;
    logic [7:0] mul_p = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    mult_arbiter dut (
        .Clk(Clk), .Rst(Rst),
        .req0(req0), .req1(req1),
        .m0(m0), .r0(r0), .m1(m1), .r1(r1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .p0(p0), .p1(p1), .err(err), .busy(busy),
        .mul_ld(mul_ld), .mul_m(mul_m), .mul_r(mul_r),
        .mul_valid(mul_valid), .mul_p(mul_p)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] sa, sb;
        sa = {{4{a[3]}}, a};
        sb = {{4{b[3]}}, b};
        return 8'(sa * sb);
    endfunction

    // ---------------- behavioural model ----------------
    // md_age: -1 no operation, 0 grant cycle, n>=1 the n-th cycle spent waiting
    int         md_age = -1;
    bit         md_owner = 1'b0, md_last = 1'b1;
    bit         md_gnt0 = 0, md_gnt1 = 0, md_done0 = 0, md_done1 = 0, md_err = 0, md_ld = 0;
    logic [3:0] md_mm = '0, md_mr = '0;
    logic [7:0] md_p0 = '0, md_p1 = '0;

    task automatic model_step();
        bit in_resp;
        if (!Rst) begin
            md_age = -1; md_last = 1'b1; md_owner = 1'b0;
            md_gnt0 = 0; md_gnt1 = 0; md_done0 = 0; md_done1 = 0; md_err = 0; md_ld = 0;
            md_mm = '0; md_mr = '0; md_p0 = '0; md_p1 = '0;
        end else begin
            in_resp = md_done0 || md_done1;
            md_gnt0 = 0; md_gnt1 = 0; md_done0 = 0; md_done1 = 0; md_err = 0; md_ld = 0;
            if (in_resp) begin
                md_age = -1;
            end else if (md_age < 0) begin
                if (req0 || req1) begin
                    md_owner = (req0 && req1) ? !md_last : req1;
                    md_last  = md_owner;
                    md_mm    = md_owner ? m1 : m0;
                    md_mr    = md_owner ? r1 : r0;
                    md_gnt0  = !md_owner;
                    md_gnt1  = md_owner;
                    md_ld    = 1;
                    md_age   = 0;
                end
            end else if (md_age == 0) begin
                md_age = 1;
            end else if (mul_valid) begin
                if (md_owner) begin md_p1 = mul_p; md_done1 = 1; end
                else          begin md_p0 = mul_p; md_done0 = 1; end
                md_age = -1;
            end else if (md_age == TMO) begin
                md_err = 1;
                md_age = -1;
            end else begin
                md_age++;
            end
        end
    endtask

    initial forever begin
        @(posedge Clk or negedge Rst);
        model_step();
    end

    // ---------------- multiplier stub ----------------
    // mode 0: product after st_lat cycles; 1: never valid;
    // 2: spurious valid during LOAD, real one 3 cycles into WAIT;
    // 3: like 0 plus random valid noise with random data
    int         st_mode = 0;
    int         st_lat = 2;
    int         st_cnt = 0;
    logic [3:0] st_a = '0, st_b = '0;

    task automatic stub_step();
        if (!Rst) begin
            mul_valid = 1'b0;
            st_cnt = 0;
        end else begin
            mul_valid = 1'b0;
            if (mul_ld) begin
                st_a = mul_m;
                st_b = mul_r;
                st_cnt = (st_mode == 2) ? 3 : st_lat;
                if (st_mode == 2) begin
                    mul_valid = 1'b1;
                    mul_p = 8'hA5;
                end
            end else if (st_cnt > 0) begin
                st_cnt--;
                if (st_cnt == 0 && st_mode != 1) begin
                    mul_valid = 1'b1;
                    mul_p = prod(st_a, st_b);
                end
            end
            if (st_mode == 3 && !mul_valid && $urandom_range(3) == 0) begin
                mul_valid = 1'b1;
                mul_p = 8'($urandom);
            end
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic [30:0] act, exp;
        @(negedge Clk);
        act = {gnt0, gnt1, done0, done1, err, busy, mul_ld, mul_m, mul_r, p0, p1};
        exp = {md_gnt0, md_gnt1, md_done0, md_done1, md_err,
               (md_age >= 0) || md_done0 || md_done1, md_ld, md_mm, md_mr, md_p0, md_p1};
        chk("cycle outputs", 32'(act), 32'(exp));
        if (done0 || done1) done_cnt++;
        if (err) err_cnt++;
        stub_step();
    end

    function automatic logic sel(input int w);
        case (w)
            0: return gnt0;
            1: return gnt1;
            2: return done0;
            3: return done1;
            4: return err;
            default: return gnt0 || gnt1;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, output bit ok, output int cyc);
        ok = 0;
        cyc = 0;
        while (!ok && cyc < budget) begin
            @(negedge Clk);
            cyc++;
            ok = sel(which);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int cyc, base_d, base_e;
        bit who[4];
        logic [7:0] pv[4];

        #1 Rst = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset busy", busy, 0);
        chk("reset p0", p0, 0);
        chk("reset p1", p1, 0);
        chk("reset mul_m", mul_m, 0);
        chk("reset gnt/done/err/ld", {gnt0, gnt1, done0, done1, err, mul_ld}, 0);
        Rst = 1'b1;

        // single request from requester 0
        st_mode = 0; st_lat = 2;
        m0 = 4'd3; r0 = 4'd5; req0 = 1'b1;
        wait_for(0, 5, ok, cyc);
        chk("gnt0 seen", ok, 1);
        chk("gnt0 latency", cyc, 1);
        chk("load mul_ld", mul_ld, 1);
        chk("load mul_m", mul_m, 4'd3);
        chk("load mul_r", mul_r, 4'd5);
        req0 = 1'b0;
        wait_for(2, 12, ok, cyc);
        chk("done0 seen", ok, 1);
        chk("p0 3*5", p0, 8'h0F);
        chk("model p0 3*5", md_p0, 8'h0F);
        chk("p1 untouched", p1, 8'h00);

        // simultaneous requests held high: alternating service
        do_reset();
        m0 = 4'd2; r0 = 4'd2; m1 = 4'hE; r1 = 4'd3;
        req0 = 1'b1; req1 = 1'b1;
        wait_for(5, 6, ok, cyc);
        chk("pair first gnt seen", ok, 1);
        for (int k = 0; k < 4; k++) begin
            who[k] = gnt1;
            if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
            wait_for(who[k] ? 3 : 2, 12, ok, cyc);
            chk("pair done seen", ok, 1);
            pv[k] = who[k] ? p1 : p0;
            if (k < 3) begin
                wait_for(5, 6, ok, cyc);
                chk("back-to-back gap", cyc, 2);
            end
        end
        chk("order 0", who[0], 0);
        chk("order 1", who[1], 1);
        chk("order 2", who[2], 0);
        chk("order 3", who[3], 1);
        chk("pair p0 2*2", pv[0], 8'h04);
        chk("pair p1 -2*3", pv[1], 8'hFA);
        chk("model p1 -2*3", md_p1, 8'hFA);

        // timeout with a multiplier that never answers
        repeat (3) @(negedge Clk);
        st_mode = 1;
        base_d = done_cnt; base_e = err_cnt;
        m0 = 4'd1; r0 = 4'd1; req0 = 1'b1;
        wait_for(0, 6, ok, cyc);
        chk("tmo gnt0 seen", ok, 1);
        req0 = 1'b0;
        wait_for(4, 40, ok, cyc);
        chk("err seen", ok, 1);
        chk("err after TMO wait cycles", cyc, TMO + 1);
        chk("busy low at err", busy, 0);
        chk("no done on timeout", done_cnt - base_d, 0);
        chk("one err", err_cnt - base_e, 1);
        st_mode = 0; st_lat = 3;
        m1 = 4'd5; r1 = 4'hF; req1 = 1'b1;
        wait_for(1, 6, ok, cyc);
        chk("post-tmo gnt1 seen", ok, 1);
        req1 = 1'b0;
        wait_for(3, 12, ok, cyc);
        chk("post-tmo done1 seen", ok, 1);
        chk("post-tmo p1 5*-1", p1, 8'hFB);

        // spurious valid during LOAD is ignored
        repeat (2) @(negedge Clk);
        st_mode = 2;
        base_d = done_cnt;
        m0 = 4'hD; r0 = 4'd4; req0 = 1'b1;
        wait_for(0, 6, ok, cyc);
        chk("spur gnt0 seen", ok, 1);
        req0 = 1'b0;
        wait_for(2, 12, ok, cyc);
        chk("spur done0 seen", ok, 1);
        chk("spur done timing", cyc, 4);
        repeat (5) @(negedge Clk);
        chk("spur single done", done_cnt - base_d, 1);
        chk("spur p0 -3*4", p0, 8'hF4);

        // asynchronous reset mid-WAIT
        st_mode = 0; st_lat = 8;
        m0 = 4'd1; r0 = 4'd2; req0 = 1'b1;
        wait_for(0, 6, ok, cyc);
        chk("rst gnt0 seen", ok, 1);
        req0 = 1'b0;
        repeat (3) @(negedge Clk);
        base_d = done_cnt; base_e = err_cnt;
        #2 Rst = 1'b0;
        #1;
        chk("async busy", busy, 0);
        chk("async p0", p0, 0);
        chk("async mul_m", mul_m, 0);
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        st_lat = 2;
        m1 = 4'h7; r1 = 4'h7; req1 = 1'b1;
        wait_for(1, 6, ok, cyc);
        chk("after rst gnt1 seen", ok, 1);
        req1 = 1'b0;
        wait_for(3, 12, ok, cyc);
        chk("after rst done1 seen", ok, 1);
        chk("after rst p1 7*7", p1, 8'h31);
        chk("after rst done count", done_cnt - base_d, 1);
        chk("after rst no err", err_cnt - base_e, 0);

        // randomized traffic, checked cycle by cycle against the model
        for (int blk = 0; blk < 4; blk++) begin
            st_mode = (blk == 2) ? 1 : ((blk == 1) ? 0 : 3);
            for (int c = 0; c < 150; c++) begin
                @(negedge Clk);
                req0 = ($urandom_range(2) != 0);
                req1 = ($urandom_range(2) != 0);
                m0 = 4'($urandom); r0 = 4'($urandom);
                m1 = 4'($urandom); r1 = 4'($urandom);
                st_lat = $urandom_range(1, 5);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (TMO + 10) @(negedge Clk);
        chk("final idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
